// File: rtl/arb_fixed_prio.sv
// Four-requester fixed-priority grant responder: grant rises GNT_DELAY cycles after the request pulse and lasts GNT_WIDTH cycles.
// No backpressure to requesters: pulses arriving while busy are queued in pend and replayed in priority order.
module arb_fixed_prio #(
  parameter int GNT_DELAY = 3,
  parameter int GNT_WIDTH = 1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       req4,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic       gnt4,
  output logic       busy,
  output logic [3:0] pend
);

  if (GNT_DELAY < 3 || GNT_DELAY > 7) begin : g_bad_delay
    $error("arb_fixed_prio: GNT_DELAY must be in 3..7");
  end
  if (GNT_WIDTH < 1 || GNT_WIDTH > 2) begin : g_bad_width
    $error("arb_fixed_prio: GNT_WIDTH must be in 1..2");
  end

  localparam logic [2:0] DELAY_LOAD = 3'(GNT_DELAY - 1);
  localparam logic [2:0] WIDTH_LOAD = 3'(GNT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [3:0] pend_nxt;
  logic [3:0] gnt, gnt_nxt;
  logic       busy_nxt;
  logic [3:0] req_vec;
  logic [3:0] req_all;
  logic [1:0] req_low;

  assign req_vec = {req4, req3, req2, req1};
  assign req_all = req_vec | pend;

  // Lowest set index wins: req1 is the highest priority.
  always_comb begin
    req_low = 2'd0;
    if (req_all[0])      req_low = 2'd0;
    else if (req_all[1]) req_low = 2'd1;
    else if (req_all[2]) req_low = 2'd2;
    else if (req_all[3]) req_low = 2'd3;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    gnt_nxt   = gnt;
    unique case (state)
      IDLE: begin
        if (req_all != 4'd0) begin
          sel_nxt   = req_low;
          pend_nxt  = req_all & ~(4'b0001 << req_low);
          cnt_nxt   = DELAY_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        pend_nxt = pend | req_vec;
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          gnt_nxt   = 4'b0001 << sel;
          cnt_nxt   = WIDTH_LOAD;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        pend_nxt = pend | req_vec;
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          gnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // busy is registered from the next state so it tracks WAIT/GRANT exactly.
  assign busy_nxt = (state_nxt != IDLE);

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      cnt   <= 3'd0;
      pend  <= 4'd0;
      gnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
    end
  end

  assign gnt1 = gnt[0];
  assign gnt2 = gnt[1];
  assign gnt3 = gnt[2];
  assign gnt4 = gnt[3];

  a_gnt_onehot : assert property (@(posedge clock) disable iff (rst) $onehot0(gnt));
  a_busy_state : assert property (@(posedge clock) disable iff (rst) busy == (state != IDLE));

endmodule

// File: doc/arb_fixed_prio.md
# arb_fixed_prio

Four-requester fixed-priority arbiter: the responder end of the `req1..req4` / `gnt1..gnt4` arbitration interface. It samples one-cycle request pulses and issues exactly one grant per accepted request. Each grant is asserted a fixed 3–7 cycles after its request and held for 1–2 cycles. Requests that arrive while a grant is in progress are queued and served in priority order once the interface is free.

## Interface

Parameters:
- `GNT_DELAY`, default 3. Cycles from the request-low edge to the first grant-high edge. Legal range 3..7; any other value is an elaboration error.
- `GNT_WIDTH`, default 1. Cycles the grant stays high. Legal range 1..2; any other value is an elaboration error.

Ports:
- `clock`  in  1  sole clock; all logic on the posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req1`..`req4`  in  1 each  request pulses; `req1` has the highest priority, `req4` the lowest.
- `gnt1`..`gnt4`  out  1 each  grant outputs, registered.
- `busy`  out  1  high in WAIT and GRANT, registered.
- `pend`  out  4  queued-request bits, {req4..req1}, registered.

## Operation

Registered state:
- FSM with states IDLE, WAIT, GRANT.
- `sel`: 2-bit index of the requester being served.
- `cnt`: 3-bit down-counter.
- `pend`: 4-bit queued-request register.

Request vector: `r = {req4,req3,req2,req1} | pend`.

IDLE:
- If `r` is 0, stay in IDLE.
- Otherwise:
  - set `sel` to the lowest set index of `r`;
  - clear that bit in `pend`;
  - set `pend` bits for all other set bits of `r`;
  - load `cnt <= GNT_DELAY-1`;
  - go to WAIT.

WAIT:
- Each edge, OR any sampled `reqN` into `pend`.
- If `cnt != 0`: decrement `cnt`.
- If `cnt == 0`:
  - drive `gnt[sel] <= 1`;
  - load `cnt <= GNT_WIDTH-1`;
  - go to GRANT.

GRANT:
- Each edge, OR any sampled `reqN` into `pend`.
- If `cnt != 0`: decrement `cnt`.
- If `cnt == 0`: drive `gnt[sel] <= 0` and go to IDLE.

Rules:
- At most one `gntN` is high at any time (one-hot or zero).
- A request re-asserted by the requester currently being served is queued in `pend` and served again later.
- A repeat request whose `pend` bit is already set is absorbed: one grant, no counting.
- Priority is strictly fixed. Starvation of low-priority requesters under continuous high-priority traffic is accepted behaviour.
- `busy` is 1 exactly while the state is WAIT or GRANT.

## Timing

Reference edge: let t0 be the edge at which IDLE accepts a request.
- For a fresh request, t0 is the first edge where `reqN` is sampled high; `reqN` is then sampled low at t0+1.
- The grant register sets at edge t0+D, where D = `GNT_DELAY`.
- Sampled by the checker:
  - `gntN` is high at edges t0+D+1 .. t0+D+W, where W = `GNT_WIDTH`;
  - it is low again at t0+D+W+1.
- Therefore `$fell(req)` at t0+1 is followed by `$rose(gnt)` exactly D edges later.

Back-to-back grants:
- A queued request is accepted one edge after the grant falls: t0' = t0+D+W+1.
- The gap between grants is therefore ≥ D+1 low cycles, so no two grants are ever adjacent.

Reset and boundary conditions:
- Reset values: all `gntN`=0, `busy`=0, `pend`=0, state IDLE, `cnt`=0, `sel`=0.
- `rst` sampled high in any state:
  - at that edge, `gnt` drops to 0, `pend` clears and the FSM returns to IDLE;
  - requests sampled on the same edge are discarded.
- Simultaneous requests in IDLE: the highest priority is served; the rest go to `pend` on the same edge.
- A request on the same edge as the grant deassert is captured into `pend` and served from the following IDLE.

## Test plan

1. `GNT_DELAY`=3, `GNT_WIDTH`=1; `req2` pulsed high at edge 10 → `gnt2` high at sampled edge 14 only, `busy` high at 11..14, `pend`=0 throughout.
2. Defaults; `req1`–`req4` all pulsed at edge 10 → grants in order `gnt1`, `gnt2`, `gnt3`, `gnt4`, each 1 cycle long; `pend`=4'b1110 at edge 11; never two `gntN` high together.
3. `GNT_DELAY`=7, `GNT_WIDTH`=2; `req3` pulsed at edge 5 → `gnt3` high at edges 13 and 14, low at edge 15.
4. Defaults; `req4` pulsed at edge 0, then `req1` pulsed at edge 2 while in WAIT → `gnt4` served first, `pend`=4'b0001; `gnt1` rises 4 edges after the IDLE that follows `gnt4` falling.
5. Defaults; `req2` pulsed at edge 0, then `rst` high at edge 2 → `gnt2` never asserts; `busy`=0 and `pend`=0 at edge 3.
6. Regression with random one-cycle pulses on all requesters for all 10 parameter combinations → every request gets exactly one grant, and D/W timing plus the one-hot rule hold on every grant.
